// File: rtl/seg_scan_driver_pkg.sv
// Shared display definitions: digit geometry, the blank segment pattern and the
// per-slot PWM state encoding.
package seg_scan_driver_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned DIG_W      = $clog2(NUM_DIGITS);
  localparam int unsigned FRAME_W    = NUM_DIGITS * SEG_W;

  localparam logic [SEG_W-1:0] BLANK_SEG = 7'h7F;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    ON    = 2'd1,
    OFF   = 2'd2
  } slot_state_e;

  // Active-low one-hot anode pattern for a digit index.
  function automatic logic [NUM_DIGITS-1:0] anode_sel_n(input logic [DIG_W-1:0] digit);
    return ~(NUM_DIGITS'(1) << digit);
  endfunction

endpackage

// File: rtl/seg_pwm_slot.sv
// Per-digit slot timer: blanking window, brightness-scaled on-window, then off
// until the slot wraps.
module seg_pwm_slot
  import seg_scan_driver_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES  = 6250,
  parameter int unsigned BLANK_CYCLES = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] brightness,
  output logic       slot_wrap_c,
  output logic       slot_start_c,
  output logic       on_window_c
);

  localparam int unsigned CNT_W = $clog2(SLOT_CYCLES);
  localparam int unsigned UNIT  = (SLOT_CYCLES - BLANK_CYCLES) >> 3;

  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [2:0]       bright_q;
  logic [CNT_W-1:0] on_len, on_last;
  slot_state_e      state_q, state_d;

  assign slot_wrap_c  = (slot_cnt_q == CNT_W'(SLOT_CYCLES - 1));
  assign slot_start_c = (slot_cnt_q == '0);
  assign on_window_c  = (state_q == ON);

  // Last slot_cnt value of the on-window for the brightness latched this slot.
  assign on_len  = CNT_W'(UNIT) * CNT_W'({1'b0, bright_q} + 4'd1);
  assign on_last = CNT_W'(BLANK_CYCLES) + on_len - CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q <= '0;
      state_q    <= BLANK;
      bright_q   <= 3'd7;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      state_q    <= state_d;
      if (slot_start_c) begin
        bright_q <= brightness;
      end
    end
  end

  // Slot wrap takes priority so full brightness never visits OFF.
  always_comb begin
    slot_cnt_d = slot_cnt_q + CNT_W'(1);
    state_d    = state_q;
    if (slot_wrap_c) begin
      slot_cnt_d = '0;
    end
    case (state_q)
      BLANK: begin
        if (slot_cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          state_d = ON;
        end
      end
      ON: begin
        if (slot_wrap_c) begin
          state_d = BLANK;
        end else if (slot_cnt_q == on_last) begin
          state_d = OFF;
        end
      end
      OFF: begin
        if (slot_wrap_c) begin
          state_d = BLANK;
        end
      end
      default: state_d = BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexes a frame-snapshotted 8-digit segment vector onto one shared
// 7-segment bus with active-low digit enables.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES  = 6250,
  parameter int unsigned BLANK_CYCLES = 250
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FRAME_W-1:0]    seg_in,
  input  logic                  en,
  input  logic [2:0]            brightness,
  output logic [SEG_W-1:0]      seg_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame_start
);

  logic                                slot_wrap_c;
  logic                                slot_start_c;
  logic                                on_window_c;
  logic                                frame_load_c;
  logic [DIG_W-1:0]                    digit_q;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]    frame_q;

  seg_pwm_slot #(
    .SLOT_CYCLES  (SLOT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_slot (
    .clk          (clk),
    .rst_n        (rst_n),
    .brightness   (brightness),
    .slot_wrap_c  (slot_wrap_c),
    .slot_start_c (slot_start_c),
    .on_window_c  (on_window_c)
  );

  assign frame_load_c = slot_start_c && (digit_q == '0);

  // Digit counter and whole-frame snapshot taken at the start of digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
      frame_q <= '1;
    end else begin
      if (slot_wrap_c) begin
        digit_q <= digit_q + DIG_W'(1);
      end
      if (frame_load_c) begin
        frame_q <= seg_in;
      end
    end
  end

  // Registered outputs; segments follow the on-window regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n        <= '1;
      seg_n       <= BLANK_SEG;
      frame_start <= 1'b0;
    end else begin
      an_n        <= (on_window_c && en) ? anode_sel_n(digit_q) : '1;
      seg_n       <= on_window_c ? frame_q[digit_q] : BLANK_SEG;
      frame_start <= frame_load_c;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with an 18-cycle slot and 2-cycle blanking.
module tb_seg_scan_driver;

  localparam int SLOT  = 18;
  localparam int FRAME = SLOT * 8;
  localparam int NV    = 40;

  typedef struct {
    int         k;
    logic [2:0] br;
    logic       en;
    logic       pat;
    logic [7:0] an;
    logic [6:0] seg;
    logic       fs;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [55:0] seg_in;
  logic        en;
  logic [2:0]  brightness;
  logic [6:0]  seg_n;
  logic [7:0]  an_n;
  logic        frame_start;

  int   cyc;
  int   n_checks;
  int   n_fail;
  int   prev_zero;
  vec_t vecs [NV];
  logic [55:0] pat_p, pat_q, pat_r;

  seg_scan_driver #(
    .SLOT_CYCLES  (18),
    .BLANK_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .en          (en),
    .brightness  (brightness),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release: after posedge k this reads k.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [55:0] mk_pat(input int base, input bit shifted);
    logic [55:0] p;
    p = '0;
    for (int d = 0; d < 8; d++) begin
      if (shifted) p[d*7 +: 7] = 7'(32'(1) << d);
      else         p[d*7 +: 7] = 7'(base + d);
    end
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Advance one cycle and apply the invariants that hold on every cycle.
  task automatic step();
    int nz;
    int idx;
    @(negedge clk);
    if (rst_n && cyc >= 1) begin
      nz  = 0;
      idx = -1;
      for (int b = 0; b < 8; b++) begin
        if (an_n[b] == 1'b0) begin
          nz++;
          idx = b;
        end
      end
      check("an_at_most_one", 64'(nz <= 1), 64'd1);
      check("an_handoff", 64'(!(nz == 1 && prev_zero >= 0 && idx != prev_zero)), 64'd1);
      prev_zero = (nz == 1) ? idx : -1;
      if ((cyc - 1) % SLOT < 2) check("an_blank_window", 64'(an_n), 64'hFF);
      check("frame_start_period", 64'(frame_start), 64'((cyc - 1) % FRAME == 0));
    end
  endtask

  task automatic goto(input int k);
    int guard;
    guard = 0;
    while (cyc < k && guard < 2000) begin
      step();
      guard++;
    end
    check("goto_reached", 64'(cyc), 64'(k));
  endtask

  task automatic check_out(input string tag, input logic [7:0] an, input logic [6:0] seg, input logic fs);
    check({tag, "_an"},  64'(an_n), 64'(an));
    check({tag, "_seg"}, 64'(seg_n), 64'(seg));
    check({tag, "_fs"},  64'(frame_start), 64'(fs));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    prev_zero = -1;
    pat_p = mk_pat(0, 1'b1);
    pat_q = mk_pat(32'h30, 1'b0);
    pat_r = mk_pat(32'h50, 1'b0);

    vecs = '{
      '{  1, 3'd7, 1'b1, 1'b0, 8'hFF, 7'h7F, 1'b1},
      '{  2, 3'd7, 1'b1, 1'b0, 8'hFF, 7'h7F, 1'b0},
      '{  3, 3'd7, 1'b1, 1'b0, 8'hFE, 7'h01, 1'b0},
      '{ 18, 3'd7, 1'b1, 1'b0, 8'hFE, 7'h01, 1'b0},
      '{ 19, 3'd7, 1'b1, 1'b0, 8'hFF, 7'h7F, 1'b0},
      '{ 20, 3'd7, 1'b1, 1'b0, 8'hFF, 7'h7F, 1'b0},
      '{ 21, 3'd7, 1'b1, 1'b0, 8'hFD, 7'h02, 1'b0},
      '{ 36, 3'd7, 1'b1, 1'b0, 8'hFD, 7'h02, 1'b0},
      '{ 57, 3'd7, 1'b1, 1'b0, 8'hF7, 7'h08, 1'b0},
      '{111, 3'd7, 1'b1, 1'b0, 8'hBF, 7'h40, 1'b0},
      '{129, 3'd7, 1'b1, 1'b0, 8'h7F, 7'h00, 1'b0},
      '{144, 3'd7, 1'b1, 1'b0, 8'h7F, 7'h00, 1'b0},
      '{145, 3'd7, 1'b1, 1'b0, 8'hFF, 7'h7F, 1'b1},
      '{147, 3'd7, 1'b1, 1'b0, 8'hFE, 7'h01, 1'b0},
      '{160, 3'd0, 1'b1, 1'b0, 8'hFE, 7'h01, 1'b0},
      '{162, 3'd0, 1'b1, 1'b0, 8'hFE, 7'h01, 1'b0},
      '{163, 3'd0, 1'b1, 1'b0, 8'hFF, 7'h7F, 1'b0},
      '{165, 3'd0, 1'b1, 1'b0, 8'hFD, 7'h02, 1'b0},
      '{166, 3'd0, 1'b1, 1'b0, 8'hFD, 7'h02, 1'b0},
      '{167, 3'd0, 1'b1, 1'b0, 8'hFF, 7'h7F, 1'b0},
      '{170, 3'd3, 1'b1, 1'b0, 8'hFF, 7'h7F, 1'b0},
      '{180, 3'd3, 1'b1, 1'b0, 8'hFF, 7'h7F, 1'b0},
      '{182, 3'd3, 1'b1, 1'b0, 8'hFF, 7'h7F, 1'b0},
      '{183, 3'd3, 1'b1, 1'b0, 8'hFB, 7'h04, 1'b0},
      '{184, 3'd3, 1'b0, 1'b0, 8'hFB, 7'h04, 1'b0},
      '{185, 3'd3, 1'b0, 1'b0, 8'hFF, 7'h04, 1'b0},
      '{189, 3'd3, 1'b1, 1'b0, 8'hFF, 7'h04, 1'b0},
      '{190, 3'd3, 1'b1, 1'b0, 8'hFB, 7'h04, 1'b0},
      '{191, 3'd3, 1'b1, 1'b0, 8'hFF, 7'h7F, 1'b0},
      '{200, 3'd3, 1'b1, 1'b0, 8'hFF, 7'h7F, 1'b0},
      '{201, 3'd3, 1'b1, 1'b0, 8'hF7, 7'h08, 1'b0},
      '{205, 3'd3, 1'b1, 1'b1, 8'hF7, 7'h08, 1'b0},
      '{219, 3'd3, 1'b1, 1'b1, 8'hEF, 7'h10, 1'b0},
      '{237, 3'd3, 1'b1, 1'b1, 8'hDF, 7'h20, 1'b0},
      '{273, 3'd3, 1'b1, 1'b1, 8'h7F, 7'h00, 1'b0},
      '{289, 3'd3, 1'b1, 1'b1, 8'hFF, 7'h7F, 1'b1},
      '{291, 3'd3, 1'b1, 1'b1, 8'hFE, 7'h30, 1'b0},
      '{309, 3'd3, 1'b1, 1'b1, 8'hFD, 7'h31, 1'b0},
      '{440, 3'd3, 1'b1, 1'b1, 8'hFE, 7'h30, 1'b0},
      '{527, 3'd3, 1'b1, 1'b1, 8'hDF, 7'h35, 1'b0}
    };

    rst_n      = 1'b0;
    seg_in     = pat_p;
    en         = 1'b1;
    brightness = 3'd7;
    repeat (3) @(negedge clk);
    check_out("reset", 8'hFF, 7'h7F, 1'b0);
    #1 rst_n = 1'b1;

    // Table: check outputs at cycle k, then apply that record's inputs.
    for (int i = 0; i < NV; i++) begin
      goto(vecs[i].k);
      check_out($sformatf("vec%0d", i), vecs[i].an, vecs[i].seg, vecs[i].fs);
      brightness = vecs[i].br;
      en         = vecs[i].en;
      seg_in     = vecs[i].pat ? pat_q : pat_p;
    end

    // Asynchronous reset in the middle of digit 5's on-window.
    #1 rst_n = 1'b0;
    #1 check_out("rst_async", 8'hFF, 7'h7F, 1'b0);
    prev_zero  = -1;
    seg_in     = pat_r;
    brightness = 3'd7;
    repeat (2) @(negedge clk);
    check_out("rst_hold", 8'hFF, 7'h7F, 1'b0);
    #1 rst_n = 1'b1;
    goto(1);
    check_out("rerun_c1", 8'hFF, 7'h7F, 1'b1);
    goto(2);
    check_out("rerun_c2", 8'hFF, 7'h7F, 1'b0);
    goto(3);
    check_out("rerun_c3", 8'hFE, 7'h50, 1'b0);
    goto(18);
    check_out("rerun_c18", 8'hFE, 7'h50, 1'b0);
    goto(21);
    check_out("rerun_c21", 8'hFD, 7'h51, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
